ir_fetch_queue: RTL and testbench

//  2-wide instruction queue between the fetch stage and dual-issue decode.
//  - Fetch pushes up to two ir_reg_t entries per cycle; decode pops up to two per cycle, in order.
//  - Decouples fetch timing from decode stalls.
//  - Discards all contents on a pipeline flush (branch mispredict, trap, fence.i).

---
 rtl/ir_fetch_queue.sv | 123 ++++++++++++
 tb/tb_ir_fetch_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue: 2-wide in-order instruction queue between fetch and decode.
// Optional same-cycle bypass when empty: define IR_FETCH_QUEUE_BYPASS_EN.
package ir_fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ir_reg_t;

    localparam ir_reg_t NULL_IR_REG = '0;
endpackage

module ir_fetch_queue
    import ir_fetch_queue_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [1:0]                 push_valid_i,
    input  ir_reg_t                    push_data0_i,
    input  ir_reg_t                    push_data1_i,
    output logic                       push_ready_o,
    output logic [1:0]                 out_valid_o,
    output ir_reg_t                    out_data0_o,
    output ir_reg_t                    out_data1_o,
    input  logic [1:0]                 pop_i,
    output logic [$clog2(Depth+1)-1:0] count_o
);
    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    ir_reg_t         r_mem [Depth];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [1:0]      w_push_v;
    logic [1:0]      w_pop_v;
    logic [1:0]      w_push_act;
    logic [1:0]      w_n_push;
    logic [1:0]      w_n_pop;
    logic [1:0]      w_skip;
    logic [1:0]      w_n_store;
    logic            w_bypass;
    logic [AW-1:0]   w_rd_ptr1;
    logic [AW-1:0]   w_wr_ptr1;
    ir_reg_t         w_st0;
    ir_reg_t         w_d0;
    ir_reg_t         w_d1;
    logic [1:0]      w_valid;

    // Illegal 2'b10 encodings collapse to "nothing".
    assign w_push_v = (push_valid_i == 2'b10) ? 2'b00 : push_valid_i;
    assign w_pop_v  = (pop_i == 2'b10) ? 2'b00 : pop_i;

    assign push_ready_o = (r_count <= CW'(Depth - 2));
    assign w_push_act   = w_push_v & {2{push_ready_o}};
    assign w_n_push     = {1'b0, w_push_act[0]} + {1'b0, w_push_act[1]};

`ifdef IR_FETCH_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && !flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_rd_ptr1 = r_rd_ptr + AW'(1);
    assign w_wr_ptr1 = r_wr_ptr + AW'(1);

    always_comb begin
        w_valid = {r_count >= CW'(2), r_count >= CW'(1)};
        w_d0    = r_mem[r_rd_ptr];
        w_d1    = r_mem[w_rd_ptr1];
        if (w_bypass) begin
            w_valid = w_push_act;
            w_d0    = push_data0_i;
            w_d1    = push_data1_i;
        end
    end

    assign out_valid_o = w_valid;
    assign out_data0_o = w_valid[0] ? w_d0 : NULL_IR_REG;
    assign out_data1_o = w_valid[1] ? w_d1 : NULL_IR_REG;
    assign count_o     = r_count;

    assign w_n_pop = {1'b0, w_pop_v[0] & w_valid[0]}
                   + {1'b0, w_pop_v[1] & w_valid[1]};

    // Bypassed entries consumed this cycle are never stored.
    assign w_skip    = w_bypass ? w_n_pop : 2'd0;
    assign w_n_store = w_n_push - w_skip;
    assign w_st0     = (w_skip == 2'd0) ? push_data0_i : push_data1_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            if (w_n_store >= 2'd1)
                r_mem[r_wr_ptr] <= w_st0;
            if (w_n_store == 2'd2)
                r_mem[w_wr_ptr1] <= push_data1_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_store);
            r_rd_ptr <= r_rd_ptr + AW'(w_n_pop - w_skip);
            r_count  <= r_count + CW'(w_n_push) - CW'(w_n_pop);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (push_valid_i != 2'b10);
            assert (pop_i != 2'b10);
        end
    end
`endif
endmodule

// File: tb/tb_ir_fetch_queue.sv
// Directed testbench for ir_fetch_queue (Depth 8).
// Table-driven main flow plus wrap, flush and bypass sequences.
module tb_ir_fetch_queue;
    import ir_fetch_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] push_v;
    ir_reg_t    pd0, pd1;
    logic       ready;
    logic [1:0] ov;
    ir_reg_t    od0, od1;
    logic [1:0] pop;
    logic [3:0] cnt;

    int checks = 0;
    int failures = 0;

    ir_fetch_queue #(.Depth(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .push_valid_i(push_v),
        .push_data0_i(pd0),
        .push_data1_i(pd1),
        .push_ready_o(ready),
        .out_valid_o (ov),
        .out_data0_o (od0),
        .out_data1_o (od1),
        .pop_i       (pop),
        .count_o     (cnt)
    );

    always #5 clk = ~clk;

    function automatic ir_reg_t mk(input logic [31:0] pc);
        ir_reg_t r;
        if (pc == 32'h0) r = NULL_IR_REG;
        else begin
            r.pc    = pc;
            r.instr = pc ^ 32'h1300_0000;
        end
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [1:0] pv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] pp);
        flush  = f;
        push_v = pv;
        pd0    = mk(a);
        pd1    = mk(b);
        pop    = pp;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  pv;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  pp;
        logic [1:0]  e_v;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // expectations are the outputs seen before the row's clock edge
        tbl[0]  = '{2'b11, 32'h100, 32'h104, 2'b00, 2'b00, 4'd0, 1'b1, 32'h0,   32'h0};
        tbl[1]  = '{2'b11, 32'h108, 32'h10c, 2'b00, 2'b11, 4'd2, 1'b1, 32'h100, 32'h104};
        tbl[2]  = '{2'b11, 32'h110, 32'h114, 2'b00, 2'b11, 4'd4, 1'b1, 32'h100, 32'h104};
        tbl[3]  = '{2'b11, 32'h118, 32'h11c, 2'b00, 2'b11, 4'd6, 1'b1, 32'h100, 32'h104};
        tbl[4]  = '{2'b11, 32'h200, 32'h204, 2'b00, 2'b11, 4'd8, 1'b0, 32'h100, 32'h104};
        tbl[5]  = '{2'b00, 32'h0,   32'h0,   2'b01, 2'b11, 4'd8, 1'b0, 32'h100, 32'h104};
        tbl[6]  = '{2'b11, 32'h208, 32'h20c, 2'b00, 2'b11, 4'd7, 1'b0, 32'h104, 32'h108};
        tbl[7]  = '{2'b00, 32'h0,   32'h0,   2'b11, 2'b11, 4'd7, 1'b0, 32'h104, 32'h108};
        tbl[8]  = '{2'b00, 32'h0,   32'h0,   2'b11, 2'b11, 4'd5, 1'b1, 32'h10c, 32'h110};
        tbl[9]  = '{2'b01, 32'h120, 32'h999, 2'b11, 2'b11, 4'd3, 1'b1, 32'h114, 32'h118};
        tbl[10] = '{2'b00, 32'h0,   32'h0,   2'b01, 2'b11, 4'd2, 1'b1, 32'h11c, 32'h120};
        tbl[11] = '{2'b00, 32'h0,   32'h0,   2'b11, 2'b01, 4'd1, 1'b1, 32'h120, 32'h0};
        tbl[12] = '{2'b00, 32'h0,   32'h0,   2'b11, 2'b00, 4'd0, 1'b1, 32'h0,   32'h0};
        tbl[13] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 4'd0, 1'b1, 32'h0,   32'h0};

        rst = 1'b1;
        drive(1'b0, 2'b00, 0, 0, 2'b00);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(ov), 64'(2'b00));
        chk("rst_ready", 64'(ready), 64'(1'b1));
        chk("rst_count", 64'(cnt), 64'(0));

`ifndef IR_FETCH_QUEUE_BYPASS_EN
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, tbl[i].pv, tbl[i].a, tbl[i].b, tbl[i].pp);
            #1;
            chk($sformatf("t%0d_valid", i), 64'(ov), 64'(tbl[i].e_v));
            chk($sformatf("t%0d_count", i), 64'(cnt), 64'(tbl[i].e_cnt));
            chk($sformatf("t%0d_ready", i), 64'(ready), 64'(tbl[i].e_rdy));
            chk($sformatf("t%0d_d0", i), od0, mk(tbl[i].e_pc0));
            chk($sformatf("t%0d_d1", i), od1, mk(tbl[i].e_pc1));
            step();
        end

        // wrap: steady push 11 / pop 11 across several pointer wraps
        begin
            logic [31:0] nxt;
            logic [31:0] exp_pc;
            nxt    = 32'h1000;
            exp_pc = 32'h1000;
            for (int c = 0; c < 20; c++) begin
                drive(1'b0, 2'b11, nxt, nxt + 4, 2'b11);
                #1;
                chk($sformatf("w%0d_count", c), 64'(cnt),
                    64'((c == 0) ? 0 : 2));
                if (c > 0) begin
                    chk($sformatf("w%0d_d0", c), od0, mk(exp_pc));
                    chk($sformatf("w%0d_d1", c), od1, mk(exp_pc + 4));
                    exp_pc += 8;
                end
                nxt += 8;
                step();
            end
            drive(1'b0, 2'b00, 0, 0, 2'b11);
            #1;
            chk("w_last_d0", od0, mk(exp_pc));
            step();
            drive(1'b0, 2'b00, 0, 0, 2'b00);
            #1;
            chk("w_drained", 64'(cnt), 64'(0));
        end

        // flush at count 5 with simultaneous push and pop
        drive(1'b0, 2'b11, 32'h300, 32'h304, 2'b00);
        step();
        drive(1'b0, 2'b11, 32'h308, 32'h30c, 2'b00);
        step();
        drive(1'b0, 2'b01, 32'h310, 32'h0, 2'b00);
        step();
        #1;
        chk("f_count5", 64'(cnt), 64'(5));
        drive(1'b1, 2'b11, 32'h400, 32'h404, 2'b11);
        #1;
        chk("f_valid_during", 64'(ov), 64'(2'b11));
        step();
        drive(1'b0, 2'b00, 0, 0, 2'b00);
        #1;
        chk("f_count0", 64'(cnt), 64'(0));
        chk("f_valid0", 64'(ov), 64'(2'b00));
        chk("f_null0", od0, mk(0));
        drive(1'b0, 2'b11, 32'h500, 32'h504, 2'b00);
        step();
        drive(1'b0, 2'b00, 0, 0, 2'b00);
        #1;
        chk("f_new_count", 64'(cnt), 64'(2));
        chk("f_new_d0", od0, mk(32'h500));
        chk("f_new_d1", od1, mk(32'h504));
`else
        // bypass: empty queue, push 11 and pop 01 in the same cycle
        drive(1'b0, 2'b11, 32'h700, 32'h704, 2'b01);
        #1;
        chk("b_valid", 64'(ov), 64'(2'b11));
        chk("b_d0", od0, mk(32'h700));
        chk("b_d1", od1, mk(32'h704));
        step();
        drive(1'b0, 2'b00, 0, 0, 2'b00);
        #1;
        chk("b_count", 64'(cnt), 64'(1));
        chk("b_valid_n", 64'(ov), 64'(2'b01));
        chk("b_head", od0, mk(32'h704));
        step();
        #1;
        chk("b_hold", 64'(cnt), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
